// File: rtl/sine_wave_gen.sv
// Free-running sine source: phase accumulator addressing a quarter-wave ROM with quadrant folding.
// One clock from held phase to registered data_out; en=0 freezes phase and output (no backpressure).
module sine_wave_gen #(
   parameter int ACC_W      = 8,
   parameter int PHASE_STEP = 1
) (
   input  logic              Clk,
   input  logic              reset,
   input  logic              en,
   output logic signed [7:0] data_out
);

   logic [ACC_W-1:0]  acc;
   logic [7:0]        p;
   logic [1:0]        q;
   logic [5:0]        o;
   logic [6:0]        idx;
   logic [6:0]        mag;
   logic signed [7:0] sample;

   // Q[k] = round(127*sin(pi*k/128)), k = 0..64
   function automatic logic [6:0] qrom(input logic [6:0] k);
      logic [6:0] v;
      case (k)
         7'd0:  v = 7'd0;    7'd1:  v = 7'd3;    7'd2:  v = 7'd6;    7'd3:  v = 7'd9;
         7'd4:  v = 7'd12;   7'd5:  v = 7'd16;   7'd6:  v = 7'd19;   7'd7:  v = 7'd22;
         7'd8:  v = 7'd25;   7'd9:  v = 7'd28;   7'd10: v = 7'd31;   7'd11: v = 7'd34;
         7'd12: v = 7'd37;   7'd13: v = 7'd40;   7'd14: v = 7'd43;   7'd15: v = 7'd46;
         7'd16: v = 7'd49;   7'd17: v = 7'd51;   7'd18: v = 7'd54;   7'd19: v = 7'd57;
         7'd20: v = 7'd60;   7'd21: v = 7'd63;   7'd22: v = 7'd65;   7'd23: v = 7'd68;
         7'd24: v = 7'd71;   7'd25: v = 7'd73;   7'd26: v = 7'd76;   7'd27: v = 7'd78;
         7'd28: v = 7'd81;   7'd29: v = 7'd83;   7'd30: v = 7'd85;   7'd31: v = 7'd88;
         7'd32: v = 7'd90;   7'd33: v = 7'd92;   7'd34: v = 7'd94;   7'd35: v = 7'd96;
         7'd36: v = 7'd98;   7'd37: v = 7'd100;  7'd38: v = 7'd102;  7'd39: v = 7'd104;
         7'd40: v = 7'd106;  7'd41: v = 7'd107;  7'd42: v = 7'd109;  7'd43: v = 7'd111;
         7'd44: v = 7'd112;  7'd45: v = 7'd113;  7'd46: v = 7'd115;  7'd47: v = 7'd116;
         7'd48: v = 7'd117;  7'd49: v = 7'd118;  7'd50: v = 7'd120;  7'd51: v = 7'd121;
         7'd52: v = 7'd122;  7'd53: v = 7'd122;  7'd54: v = 7'd123;  7'd55: v = 7'd124;
         7'd56: v = 7'd125;  7'd57: v = 7'd125;  7'd58: v = 7'd126;  7'd59: v = 7'd126;
         7'd60: v = 7'd126;  7'd61: v = 7'd127;  7'd62: v = 7'd127;  7'd63: v = 7'd127;
         7'd64: v = 7'd127;
         default: v = 7'd0;
      endcase
      return v;
   endfunction

   always_comb begin
      p   = acc[ACC_W-1 -: 8];
      q   = p[7:6];
      o   = p[5:0];
      // odd quadrants read the quarter-wave backwards
      idx = q[0] ? (7'd64 - {1'b0, o}) : {1'b0, o};
      mag = qrom(idx);
      sample = q[1] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
   end

   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         acc      <= '0;
         data_out <= '0;
      end else if (en) begin
         acc      <= acc + ACC_W'(PHASE_STEP);
         data_out <= sample;
      end
   end

endmodule

// File: tb/tb_sine_wave_gen.sv
// Randomized bench for sine_wave_gen: three parameterisations against a $sin-based reference model.
module tb_sine_wave_gen;

   localparam real PI = 3.14159265358979323846;

   logic Clk = 1'b0;
   logic clk_run = 1'b1;
   logic reset;
   logic en;
   logic signed [7:0] d0, d1, d2;

   int n_checks = 0;
   int n_fail   = 0;
   int m_acc[3];
   int m_out[3];
   int samp[256];

   always #5 if (clk_run) Clk = ~Clk;

   sine_wave_gen #(.ACC_W(8),  .PHASE_STEP(1))  u0 (.Clk(Clk), .reset(reset), .en(en), .data_out(d0));
   sine_wave_gen #(.ACC_W(8),  .PHASE_STEP(64)) u1 (.Clk(Clk), .reset(reset), .en(en), .data_out(d1));
   sine_wave_gen #(.ACC_W(10), .PHASE_STEP(1))  u2 (.Clk(Clk), .reset(reset), .en(en), .data_out(d2));

   function automatic int step_of(input int i);
      return (i == 1) ? 64 : 1;
   endfunction

   function automatic int aw_of(input int i);
      return (i == 2) ? 10 : 8;
   endfunction

   function automatic int dout(input int i);
      if (i == 0) return int'(d0);
      if (i == 1) return int'(d1);
      return int'(d2);
   endfunction

   // Ideal full-wave sine, rounded symmetrically about zero
   function automatic int s_ref(input int p);
      real x;
      x = 127.0 * $sin(2.0 * PI * real'(p) / 256.0);
      if (x >= 0.0) return $rtoi(x + 0.5);
      return -$rtoi(-x + 0.5);
   endfunction

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_acc[i] = 0;
         m_out[i] = 0;
      end
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < 3; i++)
         check($sformatf("%s_dut%0d", tag, i), dout(i), m_out[i]);
   endtask

   task automatic edge_go(input logic e, input string tag);
      @(negedge Clk);
      en = e;
      @(posedge Clk);
      if (e) begin
         for (int i = 0; i < 3; i++) begin
            m_out[i] = s_ref(m_acc[i] / (1 << (aw_of(i) - 8)));
            m_acc[i] = (m_acc[i] + step_of(i)) % (1 << aw_of(i));
         end
      end
      #1;
      check_all(tag);
   endtask

   initial begin
      int step64_exp[5];
      int acc10_exp[8];
      int vmax, vmin, n128;
      bit found;
      step64_exp = '{0, 127, 0, -127, 0};
      acc10_exp  = '{0, 0, 0, 0, 3, 3, 3, 3};

      reset = 1'b0;
      en    = 1'b0;
      model_reset();
      #12;
      check_all("reset");

      @(negedge Clk);
      reset = 1'b1;

      // first full period plus wrap edge
      for (int k = 1; k <= 257; k++) begin
         edge_go(1'b1, "run");
         if (k <= 256) samp[k-1] = int'(d0);
         if (k <= 5) check($sformatf("step64_e%0d", k), int'(d1), step64_exp[k-1]);
         if (k <= 8) check($sformatf("acc10_e%0d", k), int'(d2), acc10_exp[k-1]);
         case (k)
            1:   check("e1",   int'(d0), 0);
            2:   check("e2",   int'(d0), 3);
            65:  check("e65",  int'(d0), 127);
            129: check("e129", int'(d0), 0);
            193: check("e193", int'(d0), -127);
            256: check("e256", int'(d0), -3);
            257: check("e257", int'(d0), 0);
            default: ;
         endcase
      end

      vmax = -1000; vmin = 1000; n128 = 0;
      for (int p = 0; p < 256; p++) begin
         if (samp[p] > vmax) vmax = samp[p];
         if (samp[p] < vmin) vmin = samp[p];
         if (samp[p] == -128) n128++;
         check($sformatf("mirror_p%0d", p), samp[p], samp[(128 - p) & 255]);
         if (p < 128) check($sformatf("odd_p%0d", p), samp[p], -samp[p + 128]);
      end
      check("max", vmax, 127);
      check("min", vmin, -127);
      check("no_m128", n128, 0);

      // random enable pattern, long enough to wrap the 10-bit accumulator
      for (int k = 0; k < 2000; k++)
         edge_go(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, "rand");

      // hold mid-wave at 90
      found = 1'b0;
      for (int k = 0; k < 300 && !found; k++) begin
         edge_go(1'b1, "seek");
         if (d0 == 8'sd90) found = 1'b1;
      end
      check("find90", int'(found), 1);
      for (int k = 0; k < 10; k++) begin
         edge_go(1'b0, "hold");
         check("hold90", int'(d0), 90);
      end
      edge_go(1'b1, "resume");
      edge_go(1'b1, "resume");

      // asynchronous reset with the clock stopped
      clk_run = 1'b0;
      #2;
      reset = 1'b0;
      model_reset();
      #3;
      check("async_rst0", int'(d0), 0);
      check_all("async_rst");
      #10;
      reset = 1'b1;
      #3;
      clk_run = 1'b1;
      edge_go(1'b1, "rel");
      check("rel_e1", int'(d0), 0);
      edge_go(1'b1, "rel");
      check("rel_e2", int'(d0), 3);

      for (int k = 0; k < 300; k++)
         edge_go(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, "tail");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
